// File: rtl/bt656_stream_framer.sv
// 525-line BT.656 10-bit transmitter: EAV/SAV, blanking and pixel insertion.
// One registered word per cycle; pix_ready only in active video, missing pixels become blanking.
module bt656_stream_framer #(
  parameter int          WORDS_PER_LINE  = 1716,
  parameter int          LINES_PER_FRAME = 525,
  parameter int          SAV_POS         = 272,
  parameter logic [9:0]  BLANK_C         = 10'h200,
  parameter logic [9:0]  BLANK_Y         = 10'h040
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [9:0]  pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [9:0]  bt656_stream_out,
  output logic        H,
  output logic        V,
  output logic        F,
  output logic [9:0]  line_number,
  output logic        frame_start,
  output logic        underflow
);

  localparam int         WW        = $clog2(WORDS_PER_LINE);
  localparam logic [WW-1:0] W_LAST = WW'(WORDS_PER_LINE - 1);
  localparam logic [WW-1:0] W_EAV_END = WW'(4);
  localparam logic [WW-1:0] W_SAV  = WW'(SAV_POS);
  localparam logic [WW-1:0] W_ACT  = WW'(SAV_POS + 4);
  localparam logic [1:0]  SAV_LO   = 2'(SAV_POS);
  localparam logic [9:0]  LAST_LINE = 10'(LINES_PER_FRAME);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] word_cnt, word_nxt;
  logic [9:0]    line_cnt, line_nxt;

  logic          f_cur, v_cur, in_eav, in_sav, in_active;
  logic [1:0]    code_idx;
  logic [9:0]    xy_word, blank_word, pix_clamped;

  logic [9:0]    out_nxt;
  logic          h_nxt, v_nxt, f_nxt, fs_nxt, under_set;

  // The counters always describe the word that will be registered at the next edge.
  assign f_cur     = (line_cnt <= 10'd3) || (line_cnt >= 10'd266);
  assign v_cur     = (line_cnt <= 10'd19) || ((line_cnt >= 10'd264) && (line_cnt <= 10'd282));
  assign in_eav    = word_cnt < W_EAV_END;
  assign in_sav    = (word_cnt >= W_SAV) && (word_cnt < W_ACT);
  assign in_active = word_cnt >= W_ACT;
  assign code_idx  = in_eav ? word_cnt[1:0] : (word_cnt[1:0] - SAV_LO);
  assign xy_word   = {1'b1, f_cur, v_cur, in_eav, v_cur ^ in_eav, f_cur ^ in_eav,
                      f_cur ^ v_cur, f_cur ^ v_cur ^ in_eav, 2'b00};
  assign blank_word = word_cnt[0] ? BLANK_Y : BLANK_C;

  // Keep pixels out of the 000-003 / 3FC-3FF ranges reserved for timing codes.
  always_comb begin
    pix_clamped = pix_data;
    if (pix_data < 10'h004)
      pix_clamped = 10'h004;
    else if (pix_data > 10'h3FB)
      pix_clamped = 10'h3FB;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      word_cnt <= '0;
      line_cnt <= 10'd1;
    end else begin
      state    <= state_nxt;
      word_cnt <= word_nxt;
      line_cnt <= line_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    word_nxt  = word_cnt;
    line_nxt  = line_cnt;
    case (state)
      IDLE: begin
        word_nxt = '0;
        line_nxt = 10'd1;
        if (enable)
          state_nxt = RUN;
      end
      RUN: begin
        if (word_cnt == W_LAST) begin
          word_nxt = '0;
          if (line_cnt == LAST_LINE) begin
            line_nxt = 10'd1;
            if (!enable)
              state_nxt = IDLE;
          end else begin
            line_nxt = line_cnt + 10'd1;
          end
        end else begin
          word_nxt = word_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pix_ready = 1'b0;
    out_nxt   = BLANK_Y;
    h_nxt     = 1'b0;
    v_nxt     = 1'b0;
    f_nxt     = 1'b0;
    fs_nxt    = 1'b0;
    under_set = 1'b0;
    if (state == RUN) begin
      h_nxt  = !in_active;
      v_nxt  = v_cur;
      f_nxt  = f_cur;
      fs_nxt = (line_cnt == 10'd1) && (word_cnt == '0);
      if (in_eav || in_sav) begin
        case (code_idx)
          2'd0:    out_nxt = 10'h3FF;
          2'd3:    out_nxt = xy_word;
          default: out_nxt = 10'h000;
        endcase
      end else if (in_active && !v_cur) begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          out_nxt = pix_clamped;
        end else begin
          out_nxt   = blank_word;
          under_set = 1'b1;
        end
      end else begin
        out_nxt = blank_word;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bt656_stream_out <= 10'h000;
      H                <= 1'b0;
      V                <= 1'b0;
      F                <= 1'b0;
      line_number      <= 10'd1;
      frame_start      <= 1'b0;
      underflow        <= 1'b0;
    end else begin
      bt656_stream_out <= out_nxt;
      H                <= h_nxt;
      V                <= v_nxt;
      F                <= f_nxt;
      line_number      <= line_cnt;
      frame_start      <= fs_nxt;
      underflow        <= underflow | under_set;
    end
  end

endmodule

// File: tb/tb_bt656_stream_framer.sv
// Bench for bt656_stream_framer with a short line length so whole frames fit in the run.
module tb_bt656_stream_framer;

  localparam int W   = 48;
  localparam int L   = 525;
  localparam int SAV = 12;
  localparam int ACT = SAV + 4;
  localparam int NT  = 12;

  logic       clk = 1'b0;
  logic       reset_n, enable, pix_valid, pix_ready;
  logic [9:0] pix_data, bt656_stream_out, line_number;
  logic       H, V, F, frame_start, underflow;

  always #5 clk = ~clk;

  bt656_stream_framer #(.WORDS_PER_LINE(W), .LINES_PER_FRAME(L), .SAV_POS(SAV)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .bt656_stream_out(bt656_stream_out), .H(H), .V(V), .F(F),
    .line_number(line_number), .frame_start(frame_start), .underflow(underflow));

  typedef struct {
    logic [9:0] din;
    logic       vld;
    logic [9:0] exp;
  } vec_t;
  vec_t tbl [NT];

  int checks = 0, failures = 0;
  bit mrun = 0, munder = 0;
  int midx = 0, mframe = 0, cycle = 0, last_fs = -1;
  bit len_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (model line %0d word %0d)", name, act, exp,
               midx / W + 1, midx % W);
    end
  endtask

  function automatic bit f_of(input int ln);
    return (ln <= 3) || (ln >= 266);
  endfunction
  function automatic bit v_of(input int ln);
    return (ln <= 19) || (ln >= 264 && ln <= 282);
  endfunction
  function automatic logic [9:0] xy_of(input bit f, input bit v, input bit h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h, 2'b00};
  endfunction
  function automatic logic [9:0] clamp(input logic [9:0] d);
    if (d <= 10'h003) return 10'h004;
    if (d >= 10'h3FC) return 10'h3FB;
    return d;
  endfunction
  function automatic logic [9:0] blank(input int w);
    return (w % 2 == 1) ? 10'h040 : 10'h200;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_dat"}, bt656_stream_out, 10'h000);
    chk({tag, "_hvf"}, {H, V, F}, 3'b000);
    chk({tag, "_line"}, line_number, 10'd1);
    chk({tag, "_fs"}, frame_start, 1'b0);
    chk({tag, "_under"}, underflow, 1'b0);
    chk({tag, "_rdy"}, pix_ready, 1'b0);
  endtask

  // One clock: predict the word from the position in the frame, then compare after the edge.
  task automatic step();
    logic [9:0] e_out;
    bit e_h, e_v, e_f, e_fs, e_rdy, e_under, was_run;
    int e_ln, w, ln, k;
    w = midx % W;
    ln = midx / W + 1;
    was_run = mrun;
    e_out = 10'h040; e_h = 0; e_v = 0; e_f = 0; e_fs = 0; e_rdy = 0; e_ln = 1;
    e_under = munder;
    if (mrun) begin
      e_ln = ln; e_f = f_of(ln); e_v = v_of(ln); e_h = (w < ACT); e_fs = (midx == 0);
      if (w < 4 || (w >= SAV && w < ACT)) begin
        k = (w < 4) ? w : w - SAV;
        e_out = (k == 0) ? 10'h3FF : (k == 3) ? xy_of(e_f, e_v, w < 4) : 10'h000;
      end else if (w >= ACT && !e_v) begin
        e_rdy = 1;
        if (pix_valid) e_out = clamp(pix_data);
        else begin e_out = blank(w); e_under = 1; end
      end else begin
        e_out = blank(w);
      end
    end
    chk("pix_ready", pix_ready, e_rdy);
    @(posedge clk);
    #1;
    cycle++;
    munder = e_under;
    if (!mrun) begin
      if (enable) begin mrun = 1; midx = 0; mframe++; end
    end else begin
      midx++;
      if (midx == W * L) begin
        midx = 0;
        if (!enable) mrun = 0;
        else mframe++;
      end
    end
    chk("stream_dat", bt656_stream_out, e_out);
    chk("stream_flags", {H, V, F, frame_start, underflow, line_number},
        {e_h, e_v, e_f, e_fs, e_under, 10'(e_ln)});
    if (was_run) begin
      if (ln == 1 && w == 0) chk("eav0_line1", {bt656_stream_out, frame_start}, {10'h3FF, 1'b1});
      if (ln == 1 && w == 1) chk("fs_single", frame_start, 1'b0);
      if (ln == 1 && w == 3) chk("xy_line1", bt656_stream_out, 10'h3C4);
      if (ln == 4 && w == 3) chk("xy_line4", bt656_stream_out, 10'h2D8);
      if (ln == 20 && w == SAV + 3) chk("sav_xy_line20", bt656_stream_out, 10'h200);
      if (ln == 266 && w == 3) chk("xy_line266", bt656_stream_out, 10'h3C4);
    end
    if (frame_start) begin
      if (last_fs >= 0 && !len_done) begin
        chk("frame_len", cycle - last_fs, W * L);
        len_done = 1;
      end
      last_fs = cycle;
    end
  endtask

  initial begin
    int w, ln, ti;
    bit done;
    tbl[0]  = '{10'h001, 1'b1, 10'h004};
    tbl[1]  = '{10'h3FF, 1'b1, 10'h3FB};
    tbl[2]  = '{10'h000, 1'b1, 10'h004};
    tbl[3]  = '{10'h3FC, 1'b1, 10'h3FB};
    tbl[4]  = '{10'h003, 1'b1, 10'h004};
    tbl[5]  = '{10'h004, 1'b1, 10'h004};
    tbl[6]  = '{10'h3FB, 1'b1, 10'h3FB};
    tbl[7]  = '{10'h2AA, 1'b1, 10'h2AA};
    tbl[8]  = '{10'h155, 1'b0, 10'h200};
    tbl[9]  = '{10'h123, 1'b0, 10'h040};
    tbl[10] = '{10'h200, 1'b1, 10'h200};
    tbl[11] = '{10'h3FE, 1'b1, 10'h3FB};

    reset_n = 0; enable = 0; pix_valid = 0; pix_data = '0;
    #12;
    check_reset("reset");
    reset_n = 1;
    for (int i = 0; i < 5; i++) step();
    chk("idle_before_enable", bt656_stream_out, 10'h040);
    enable = 1;

    // Frame 1 and 2 with random pixels; table vectors on line 30; disable during frame 2.
    done = 0;
    for (int n = 0; n < 2 * W * L + 100 && !done; n++) begin
      w = midx % W;
      ln = midx / W + 1;
      ti = -1;
      pix_data = 10'($urandom_range(0, 1023));
      pix_valid = (mframe >= 2 || ln > 30) ? ($urandom_range(0, 9) != 0) : 1'b1;
      if (mrun && mframe == 1 && ln == 30 && w >= ACT && w < ACT + NT) begin
        ti = w - ACT;
        pix_data = tbl[ti].din;
        pix_valid = tbl[ti].vld;
        if (ti == 0) chk("underflow_clear", underflow, 1'b0);
      end
      if (mframe == 2 && ln == 200 && w == 0) enable = 0;
      step();
      if (ti >= 0) chk($sformatf("vec%0d", ti), bt656_stream_out, tbl[ti].exp);
      if (ti == 8) chk("underflow_set", underflow, 1'b1);
      if (mframe == 2 && !mrun) done = 1;
    end
    chk("reach_idle", done, 1'b1);

    pix_valid = 1;
    for (int i = 0; i < 20; i++) step();
    chk("idle_dat", bt656_stream_out, 10'h040);
    chk("idle_rdy", pix_ready, 1'b0);
    chk("underflow_sticky", underflow, 1'b1);

    // Restart, then reset asynchronously at line 100 word 30.
    enable = 1;
    done = 0;
    for (int n = 0; n < 100 * W + 100 && !done; n++) begin
      if (mrun && midx == 99 * W + 30) done = 1;
      else begin
        pix_data = 10'($urandom_range(0, 1023));
        pix_valid = ($urandom_range(0, 9) != 0);
        step();
      end
    end
    chk("reach_line100", done, 1'b1);
    #3;
    reset_n = 0;
    #1;
    check_reset("midline_reset");
    mrun = 0; midx = 0; munder = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_hold_dat", bt656_stream_out, 10'h000);
    #2;
    reset_n = 1;
    for (int i = 0; i < 3 * W + 10; i++) begin
      pix_data = 10'($urandom_range(0, 1023));
      pix_valid = ($urandom_range(0, 1) != 0);
      step();
    end
    chk("underflow_after_reset", underflow, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
